uart_cmd_ctrl: RTL and testbench

- Command sequencer sitting between the uart byte handshakes and a simple 8-bit register bus.
- Consumes framed command bytes from the uart receive side and performs one register write or read per command.
- Returns exactly one response byte per command through the uart transmit side.
- The top-level reset generator drives reset; the controller owns rx_ready and tx_valid.

---
 rtl/uart_cmd_ctrl.sv | 171 +++++++++++++++++
 tb/tb_uart_cmd_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : uart_cmd_ctrl
// Description : Command sequencer between the uart byte handshakes and an
//               8-bit register bus. It takes 'W' addr data or 'R' addr and
//               performs one bus access per command. Each command returns
//               exactly one response byte.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_cmd_ctrl #(
    parameter int         TIMEOUT  = 16,
    parameter logic [7:0] OP_WRITE = 8'h57,
    parameter logic [7:0] OP_READ  = 8'h52
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] rx_byte,
    input  logic       rx_valid,
    output logic       rx_ready,
    output logic [7:0] tx_byte,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic [7:0] bus_addr,
    output logic [7:0] bus_wdata,
    output logic       bus_we,
    output logic       bus_re,
    input  logic [7:0] bus_rdata,
    input  logic       bus_ack,
    output logic       busy,
    output logic [7:0] err_count
);

    localparam logic [7:0] c_RSP_OK      = 8'h4B;
    localparam logic [7:0] c_RSP_BADOP   = 8'h3F;
    localparam logic [7:0] c_RSP_TIMEOUT = 8'h54;
    localparam logic [7:0] c_TMO_LAST    = 8'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        GET_ADDR = 3'd1,
        GET_DATA = 3'd2,
        BUS      = 3'd3,
        SEND     = 3'd4
    } state_t;

    state_t     r_state,    w_state;
    logic       r_is_write, w_is_write;
    logic [7:0] r_tcount,   w_tcount;
    logic [7:0] w_bus_addr, w_bus_wdata, w_tx_byte, w_err_count;
    logic       w_bus_we, w_bus_re, w_tx_valid;
    logic [7:0] w_err_inc;

    // Handshake and status outputs derived from the current state only.
    always_comb begin
        rx_ready = !reset && ((r_state == IDLE) || (r_state == GET_ADDR) ||
                              (r_state == GET_DATA));
        busy     = (r_state != IDLE);
        w_err_inc = (err_count == 8'hFF) ? err_count : err_count + 8'd1;
    end

    // Register update; synchronous reset aborts any command in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= IDLE;
            r_is_write <= 1'b0;
            r_tcount   <= 8'd0;
            bus_addr   <= 8'd0;
            bus_wdata  <= 8'd0;
            bus_we     <= 1'b0;
            bus_re     <= 1'b0;
            tx_byte    <= 8'd0;
            tx_valid   <= 1'b0;
            err_count  <= 8'd0;
        end else begin
            r_state    <= w_state;
            r_is_write <= w_is_write;
            r_tcount   <= w_tcount;
            bus_addr   <= w_bus_addr;
            bus_wdata  <= w_bus_wdata;
            bus_we     <= w_bus_we;
            bus_re     <= w_bus_re;
            tx_byte    <= w_tx_byte;
            tx_valid   <= w_tx_valid;
            err_count  <= w_err_count;
        end
    end

    // Next-state and next-output logic; everything holds unless changed.
    always_comb begin
        w_state     = r_state;
        w_is_write  = r_is_write;
        w_tcount    = r_tcount;
        w_bus_addr  = bus_addr;
        w_bus_wdata = bus_wdata;
        w_bus_we    = bus_we;
        w_bus_re    = bus_re;
        w_tx_byte   = tx_byte;
        w_tx_valid  = tx_valid;
        w_err_count = err_count;

        case (r_state)
            IDLE: begin
                if (rx_valid) begin
                    if (rx_byte == OP_WRITE) begin
                        w_is_write = 1'b1;
                        w_state    = GET_ADDR;
                    end else if (rx_byte == OP_READ) begin
                        w_is_write = 1'b0;
                        w_state    = GET_ADDR;
                    end else begin
                        w_tx_byte   = c_RSP_BADOP;
                        w_tx_valid  = 1'b1;
                        w_err_count = w_err_inc;
                        w_state     = SEND;
                    end
                end
            end
            GET_ADDR: begin
                if (rx_valid) begin
                    w_bus_addr = rx_byte;
                    if (r_is_write) begin
                        w_state = GET_DATA;
                    end else begin
                        // Read strobe starts in the first BUS cycle.
                        w_bus_re = 1'b1;
                        w_tcount = 8'd0;
                        w_state  = BUS;
                    end
                end
            end
            GET_DATA: begin
                if (rx_valid) begin
                    w_bus_wdata = rx_byte;
                    w_bus_we    = 1'b1;
                    w_tcount    = 8'd0;
                    w_state     = BUS;
                end
            end
            BUS: begin
                // Ack takes priority over the timeout in the same cycle.
                if (bus_ack) begin
                    w_bus_we   = 1'b0;
                    w_bus_re   = 1'b0;
                    w_tx_byte  = r_is_write ? c_RSP_OK : bus_rdata;
                    w_tx_valid = 1'b1;
                    w_state    = SEND;
                end else if (r_tcount == c_TMO_LAST) begin
                    w_bus_we    = 1'b0;
                    w_bus_re    = 1'b0;
                    w_tx_byte   = c_RSP_TIMEOUT;
                    w_tx_valid  = 1'b1;
                    w_err_count = w_err_inc;
                    w_state     = SEND;
                end else begin
                    w_tcount = r_tcount + 8'd1;
                end
            end
            SEND: begin
                if (tx_ready) begin
                    w_tx_valid = 1'b0;
                    w_state    = IDLE;
                end
            end
            default: begin
                w_state = IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_cmd_ctrl
// Description : Directed self-checking bench for uart_cmd_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_cmd_ctrl;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] rx_byte = 8'h00;
    logic       rx_valid = 1'b0;
    logic       rx_ready;
    logic [7:0] tx_byte;
    logic       tx_valid;
    logic       tx_ready = 1'b0;
    logic [7:0] bus_addr;
    logic [7:0] bus_wdata;
    logic       bus_we;
    logic       bus_re;
    logic [7:0] bus_rdata = 8'h00;
    logic       bus_ack = 1'b0;
    logic       busy;
    logic [7:0] err_count;

    int checks   = 0;
    int failures = 0;
    int strobes;

    uart_cmd_ctrl #(
        .TIMEOUT (16),
        .OP_WRITE(8'h57),
        .OP_READ (8'h52)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .rx_byte  (rx_byte),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .tx_byte  (tx_byte),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .bus_addr (bus_addr),
        .bus_wdata(bus_wdata),
        .bus_we   (bus_we),
        .bus_re   (bus_re),
        .bus_rdata(bus_rdata),
        .bus_ack  (bus_ack),
        .busy     (busy),
        .err_count(err_count)
    );

    always #5 clock = ~clock;

    // Advance one clock and settle just past the edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Offer one byte and hold it until the controller accepts it (bounded).
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        rx_byte  = b;
        rx_valid = 1'b1;
        while (!rx_ready && n < 50) begin
            tick();
            n++;
        end
        check("rx_accept", {31'd0, rx_ready}, 32'd1);
        tick();
        rx_valid = 1'b0;
    endtask

    // Service the bus strobe; ack in cycle ack_cycle (0 = never). Returns strobe length.
    task automatic run_bus(input int ack_cycle, input logic [7:0] rdata, output int cnt);
        cnt = 0;
        for (int i = 1; i <= 40; i++) begin
            if (!(bus_we || bus_re)) break;
            cnt++;
            bus_rdata = rdata;
            bus_ack   = (i == ack_cycle);
            tick();
            bus_ack   = 1'b0;
        end
    endtask

    // Accept the pending response byte.
    task automatic take_tx();
        tx_ready = 1'b1;
        tick();
        tx_ready = 1'b0;
        check("tx_done_valid", {31'd0, tx_valid}, 32'd0);
        check("tx_done_busy", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        check("rst_rx_ready", {31'd0, rx_ready}, 32'd0);
        check("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
        check("rst_tx_byte", {24'd0, tx_byte}, 32'h00);
        check("rst_bus_we", {31'd0, bus_we}, 32'd0);
        check("rst_bus_re", {31'd0, bus_re}, 32'd0);
        check("rst_bus_addr", {24'd0, bus_addr}, 32'h00);
        check("rst_bus_wdata", {24'd0, bus_wdata}, 32'h00);
        check("rst_err", {24'd0, err_count}, 32'h00);
        check("rst_busy", {31'd0, busy}, 32'd0);
        reset = 1'b0;
        #1;
        check("idle_rx_ready", {31'd0, rx_ready}, 32'd1);

        // Write 57,10,A5 with ack in the third strobe cycle
        send_byte(8'h57);
        send_byte(8'h10);
        send_byte(8'hA5);
        check("wr_we_first", {31'd0, bus_we}, 32'd1);
        check("wr_addr", {24'd0, bus_addr}, 32'h10);
        check("wr_wdata", {24'd0, bus_wdata}, 32'hA5);
        run_bus(3, 8'h00, strobes);
        check("wr_strobe_len", strobes, 32'd3);
        check("wr_tx_valid", {31'd0, tx_valid}, 32'd1);
        check("wr_tx_byte", {24'd0, tx_byte}, 32'h4B);
        check("wr_err", {24'd0, err_count}, 32'h00);
        take_tx();

        // Read 52,3C with ack in the first strobe cycle
        send_byte(8'h52);
        send_byte(8'h3C);
        check("rd0_re_first", {31'd0, bus_re}, 32'd1);
        check("rd0_no_tx_yet", {31'd0, tx_valid}, 32'd0);
        check("rd0_addr", {24'd0, bus_addr}, 32'h3C);
        run_bus(1, 8'hC7, strobes);
        check("rd0_strobe_len", strobes, 32'd1);
        check("rd0_tx_valid", {31'd0, tx_valid}, 32'd1);
        check("rd0_tx_byte", {24'd0, tx_byte}, 32'hC7);
        take_tx();

        // Bad opcode
        send_byte(8'h00);
        check("bad_no_we", {31'd0, bus_we}, 32'd0);
        check("bad_no_re", {31'd0, bus_re}, 32'd0);
        check("bad_tx_valid", {31'd0, tx_valid}, 32'd1);
        check("bad_tx_byte", {24'd0, tx_byte}, 32'h3F);
        check("bad_err", {24'd0, err_count}, 32'h01);
        take_tx();
        send_byte(8'h52);
        send_byte(8'h01);
        run_bus(2, 8'h5A, strobes);
        check("bad_rd_strobe_len", strobes, 32'd2);
        check("bad_rd_tx_byte", {24'd0, tx_byte}, 32'h5A);
        check("bad_rd_err", {24'd0, err_count}, 32'h01);
        take_tx();

        // Timeout with no ack
        send_byte(8'h52);
        send_byte(8'h80);
        run_bus(0, 8'h00, strobes);
        check("tmo_strobe_len", strobes, 32'd16);
        check("tmo_tx_valid", {31'd0, tx_valid}, 32'd1);
        check("tmo_tx_byte", {24'd0, tx_byte}, 32'h54);
        check("tmo_err", {24'd0, err_count}, 32'h02);
        take_tx();

        // Ack in the final (16th) cycle wins over timeout
        send_byte(8'h52);
        send_byte(8'h80);
        run_bus(16, 8'h99, strobes);
        check("tmo_ack_strobe_len", strobes, 32'd16);
        check("tmo_ack_tx_byte", {24'd0, tx_byte}, 32'h99);
        check("tmo_ack_err", {24'd0, err_count}, 32'h02);
        take_tx();

        // Backpressure on tx while a new byte is offered
        send_byte(8'h57);
        send_byte(8'h20);
        send_byte(8'h11);
        run_bus(1, 8'h00, strobes);
        rx_byte  = 8'h52;
        rx_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            check("bp_tx_valid", {31'd0, tx_valid}, 32'd1);
            check("bp_tx_byte", {24'd0, tx_byte}, 32'h4B);
            check("bp_rx_ready", {31'd0, rx_ready}, 32'd0);
            tick();
        end
        tx_ready = 1'b1;
        tick();
        tx_ready = 1'b0;
        check("bp_idle_busy", {31'd0, busy}, 32'd0);
        check("bp_idle_rx_ready", {31'd0, rx_ready}, 32'd1);
        tick();
        rx_valid = 1'b0;
        check("bp_accepted_busy", {31'd0, busy}, 32'd1);
        send_byte(8'h05);
        check("bp_rd_addr", {24'd0, bus_addr}, 32'h05);
        run_bus(1, 8'h33, strobes);
        check("bp_rd_tx_byte", {24'd0, tx_byte}, 32'h33);
        take_tx();

        // Reset mid-command while bus_we is high
        send_byte(8'h57);
        send_byte(8'h40);
        send_byte(8'h77);
        tick();
        check("mid_we_high", {31'd0, bus_we}, 32'd1);
        reset = 1'b1;
        #1;
        check("mid_rx_ready_rst", {31'd0, rx_ready}, 32'd0);
        tick();
        check("mid_bus_we", {31'd0, bus_we}, 32'd0);
        check("mid_tx_valid", {31'd0, tx_valid}, 32'd0);
        check("mid_busy", {31'd0, busy}, 32'd0);
        check("mid_err", {24'd0, err_count}, 32'h00);
        reset    = 1'b0;
        tx_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("mid_no_response", {31'd0, tx_valid}, 32'd0);
        end
        tx_ready = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
